sram_frame_reader: RTL and testbench
====================================

# sram_frame_reader

Playback side of the SRAM pattern recorder: streams the recorded frame back out of the 256K×8 asynchronous SRAM in step with the VGA raster. Each stored byte covers a 2×2 pixel block, giving 400×300 bytes per 800×600 frame. The block sits between the SRAM pins and the colour-mapping logic. It consumes `h_count`/`v_count`/`display_en` from the sync generator and prefetches bytes through a small FIFO so that SRAM access latency never stalls the pixel stream.

## Interface
- `H_ACTIVE`, 800, active pixels per line
- `V_ACTIVE`, 600, active lines per frame
- `H_TOTAL`, 1040, pixels per line including blanking
- `V_TOTAL`, 666, lines per frame including blanking
- `LEAD`, 32, pixels before line end at which the next line's reload fires
- `RD_WAIT`, 2, extra clocks that `oe` is held low before `io` is captured
- `FIFO_DEPTH`, 4, prefetch FIFO entries (power of two)

- `clk_in`  in  1  system clock (100 MHz)
- `reset`  in  1  asynchronous, active-low reset
- `pix_ce`  in  1  one-clock pixel strobe; raster counters advance on it
- `h_count`  in  12  horizontal position from the sync generator
- `v_count`  in  12  vertical position from the sync generator
- `display_en`  in  1  high in the active region
- `rec`  in  1  record request, active-low; while low this block releases the SRAM
- `io`  in  8  SRAM data bus (read only; this block never drives it)
- `addr`  out  18  SRAM address
- `cs`  out  1  SRAM chip select, active-low
- `oe`  out  1  SRAM output enable, active-low
- `we`  out  1  SRAM write enable, active-low; tied high
- `pixel_out`  out  8  byte for the current 2×2 block, registered
- `underrun`  out  1  sticky; a pop found the FIFO empty this frame

## Operation
- **Reset values:** `addr`=0, `cs`=1, `oe`=1, `we`=1, `pixel_out`=0, `underrun`=0. FIFO is empty, `line_base`=0, `fetch_cnt`=0, FSM is in IDLE.
- **Reload event:** `pix_ce` && `h_count`==`H_TOTAL-LEAD`. The next line is `v_count+1`, or 0 when `v_count`==`V_TOTAL-1`. Reload fires only if the next line is < `V_ACTIVE`. On reload:
  - FIFO is flushed.
  - Any read in progress is aborted and the FSM goes to IDLE.
  - `fetch_ptr` is set to `line_base`.
  - `fetch_cnt` is cleared.
- **Line base:**
  - Frame reload (next line 0): `line_base` is set to 0 and `underrun` is cleared.
  - Reload whose next line is even and nonzero: `line_base` += `H_ACTIVE/2`.
  - Otherwise `line_base` is held, so each even/odd line pair reuses the same 400 bytes.
  - Width: 18 bits. The maximum address is 119999, so no wrap occurs.
- **Fetch FSM:** IDLE → SETUP → WAIT → CAPTURE → IDLE.
  - IDLE: start a fetch when `rec`=1, the FIFO is not full, and `fetch_cnt` < `H_ACTIVE/2`.
  - SETUP: `addr` is set to `fetch_ptr`, `cs`=0, `oe`=0.
  - WAIT: holds for `RD_WAIT` clocks.
  - CAPTURE: `io` is pushed into the FIFO; `fetch_ptr` and `fetch_cnt` increment; the state returns to IDLE with `cs`=`oe`=1.
- **Pop condition:** `pix_ce` && `display_en` && `h_count` < `H_ACTIVE` && `v_count` < `V_ACTIVE` && `h_count[0]`==1.
  - On a pop, `pixel_out` takes the FIFO head.
  - If the FIFO is empty, `pixel_out` is set to 0 and `underrun` is set.
- Outside the active region `pixel_out` holds its value.
- **Record mode (`rec`=0):** the FSM aborts to IDLE within one clock, with `cs`=`oe`=1. The FIFO keeps its contents, and pops continue and may underrun. When `rec` returns to 1, fetching resumes at the next reload, not mid-line.
- **Simultaneous events:**
  - Push and pop in the same clock: both occur and the count is unchanged.
  - Reload in the same clock as CAPTURE: reload wins and the byte is discarded.
  - Reload and pop cannot coincide because reload falls in blanking.

## Timing
- Read cost is `3+RD_WAIT` clocks (5 at default). A pop occurs at most every 8 clocks with `pix_ce`=clk/4, so the FIFO refills faster than it drains.
- Prefetch: `LEAD`×4 = 128 clocks before the first pop, which fills all 4 entries.
- `io` is sampled on the clock edge that ends WAIT, i.e. `oe` has been low for `RD_WAIT+1` clocks.
- `pixel_out` updates on the clock after the pop-qualifying `pix_ce`.
- Asynchronous reset mid-read drives `cs`/`oe` high immediately, with no bus contention.

## Test plan
- Fill SRAM model with `mem[i]=i[7:0]`, run line 0 → `addr` sequence 0,1,2,…; `pixel_out` shows 0,1,2,… changing every 2 pixels; `underrun`=0.
- Lines 2 and 3 → both start reading at 400; line 4 starts at 800; last active line 599 starts at 119600.
- Full frame then wrap into frame 2 → line 0 reads from `addr` 0 again; `underrun` is cleared at the frame reload.
- Hold `rec`=0 from mid-line 10 → `cs`=`oe`=1 within 1 clock and no further `addr` changes. `underrun`=1 once the 4 buffered bytes are consumed. Release `rec` → line 12 plays correctly (base 2400).
- SRAM model with `RD_WAIT` forced to 6 (9-clock reads) → `underrun` asserts during line 0 and `pixel_out`=0 on the starved pops.
- Assert `reset`=0 during WAIT → `cs`, `oe`, `addr`, `pixel_out`, and `underrun` go to their reset values asynchronously. After release, the first fetch waits for a reload event.

Source files
------------

// File: rtl/sram_frame_reader.sv
`default_nettype none
// sram_frame_reader: streams a 400x300-byte frame from a 256Kx8 async SRAM in
// step with the VGA raster; one byte per 2x2 pixel block, via a prefetch FIFO.
module sram_frame_reader #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int H_TOTAL    = 1040,
  parameter int V_TOTAL    = 666,
  parameter int LEAD       = 32,
  parameter int RD_WAIT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic [11:0] h_count,
  input  logic [11:0] v_count,
  input  logic        display_en,
  input  logic        rec,
  input  logic [7:0]  io,
  output logic [17:0] addr,
  output logic        cs,
  output logic        oe,
  output logic        we,
  output logic [7:0]  pixel_out,
  output logic        underrun
);

  localparam int HALF = H_ACTIVE / 2;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(HALF + 1);
  localparam int WW   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_CAPTURE} state_t;
  state_t r_state, w_state_nxt;

  logic [11:0]   w_next_line;
  logic          w_reload, w_frame, w_pop, w_push, w_start, w_full, w_empty;
  logic [17:0]   r_line_base, r_fetch_ptr, w_base_nxt;
  logic [CW-1:0] r_fetch_cnt;
  logic [PW:0]   r_wr_ptr, r_rd_ptr, w_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [7:0]    r_cap, r_pixel;
  logic [WW-1:0] r_wait_cnt;
  logic [17:0]   r_addr;
  logic          r_cs, r_oe, r_armed, r_underrun;

  assign w_next_line = (v_count == 12'(V_TOTAL - 1)) ? 12'd0 : v_count + 12'd1;
  assign w_reload    = pix_ce && (h_count == 12'(H_TOTAL - LEAD)) &&
                       (w_next_line < 12'(V_ACTIVE));
  assign w_frame     = w_reload && (w_next_line == 12'd0);
  assign w_pop       = pix_ce && display_en && (h_count < 12'(H_ACTIVE)) &&
                       (v_count < 12'(V_ACTIVE)) && h_count[0];
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_count == FULL_CNT);
  assign w_empty     = (w_count == '0);
  // A byte captured in the same clock as a reload belongs to the old line.
  assign w_push      = (r_state == S_CAPTURE) && !w_reload;
  // Fetching is armed only by a reload seen with rec high, so it never resumes mid-line.
  assign w_start     = r_armed && rec && !w_full && (r_fetch_cnt < CW'(HALF));

  always_comb begin
    w_base_nxt = r_line_base;
    if (w_next_line == 12'd0)
      w_base_nxt = 18'd0;
    else if (!w_next_line[0])
      w_base_nxt = r_line_base + 18'(HALF);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_SETUP;
      S_SETUP:   w_state_nxt = S_WAIT;
      S_WAIT:    if (r_wait_cnt == WW'(RD_WAIT - 1)) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (w_reload || !rec)
      w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_addr     <= '0;
      r_cs       <= 1'b1;
      r_oe       <= 1'b1;
      r_cap      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + WW'(1) : '0;
      // Bus is driven only in SETUP/WAIT; io is latched on the edge leaving WAIT.
      r_cs       <= !(w_state_nxt == S_SETUP || w_state_nxt == S_WAIT);
      r_oe       <= !(w_state_nxt == S_SETUP || w_state_nxt == S_WAIT);
      if (r_state == S_IDLE && w_state_nxt == S_SETUP)
        r_addr <= r_fetch_ptr;
      if (r_state == S_WAIT && w_state_nxt == S_CAPTURE)
        r_cap <= io;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_line_base <= '0;
      r_fetch_ptr <= '0;
      r_fetch_cnt <= '0;
      r_armed     <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else if (w_reload) begin
      r_line_base <= w_base_nxt;
      r_fetch_ptr <= w_base_nxt;
      r_fetch_cnt <= '0;
      r_armed     <= rec;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      if (!rec)
        r_armed <= 1'b0;
      if (w_push) begin
        r_fetch_ptr <= r_fetch_ptr + 18'd1;
        r_fetch_cnt <= r_fetch_cnt + CW'(1);
        r_wr_ptr    <= r_wr_ptr + (PW+1)'(1);
      end
      if (w_pop && !w_empty)
        r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push)
      r_mem[r_wr_ptr[PW-1:0]] <= r_cap;
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_pixel    <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_frame)
        r_underrun <= 1'b0;
      if (w_pop) begin
        if (w_empty) begin
          r_pixel    <= 8'd0;
          r_underrun <= 1'b1;
        end else begin
          r_pixel <= r_mem[r_rd_ptr[PW-1:0]];
        end
      end
    end
  end

  assign addr      = r_addr;
  assign cs        = r_cs;
  assign oe        = r_oe;
  assign we        = 1'b1;
  assign pixel_out = r_pixel;
  assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
`default_nettype none
// Bench for sram_frame_reader: directed raster playback with a pixel
// scoreboard, an SRAM address monitor and a slow-SRAM companion instance.
module tb_sram_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_ce;
  logic [11:0] h, v;
  logic        de, rec;
  logic [7:0]  io1, io2, pix1, pix2;
  logic [17:0] addr1, addr2;
  logic        cs1, oe1, we1, und1, cs2, oe2, we2, und2;

  int checks = 0;
  int errors = 0;
  int reads  = 0;
  int m_next = 0;
  int m_left = 0;
  logic [17:0] exp_addr = '0;
  logic        mon_en = 1'b0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  // SRAM models: mem[i] = i[7:0]
  assign io1 = (!cs1 && !oe1) ? addr1[7:0] : 8'h00;
  assign io2 = (!cs2 && !oe2) ? addr2[7:0] : 8'h00;

  sram_frame_reader u_dut (
    .clk_in(clk), .reset(rst_n), .pix_ce(pix_ce), .h_count(h), .v_count(v),
    .display_en(de), .rec(rec), .io(io1), .addr(addr1), .cs(cs1), .oe(oe1),
    .we(we1), .pixel_out(pix1), .underrun(und1));

  sram_frame_reader #(.RD_WAIT(6)) u_slow (
    .clk_in(clk), .reset(rst_n), .pix_ce(pix_ce), .h_count(h), .v_count(v),
    .display_en(de), .rec(rec), .io(io2), .addr(addr2), .cs(cs2), .oe(oe2),
    .we(we2), .pixel_out(pix2), .underrun(und2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int base_of(input int line);
    return (line / 2) * 400;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel period: pix_ce for one clock, then three idle clocks.
  task automatic px(input int hh, input int vv);
    bit         pop;
    logic [7:0] e;
    int         nl;
    logic       u2p;
    h      = 12'(hh);
    v      = 12'(vv);
    de     = (hh < 800) && (vv < 600);
    pix_ce = 1'b1;
    pop    = de && (hh % 2 == 1);
    if (pop) begin
      if (m_left != 0) begin
        e = 8'(m_next);
        m_next++;
        if (m_left > 0) m_left--;
      end else begin
        e = 8'h00;
      end
      sb.push_back(e);
    end
    u2p = und2;
    tick();
    pix_ce = 1'b0;
    if (pop) begin
      e = sb.pop_front();
      chk("pixel", 32'(pix1), 32'(e));
      if (!u2p && und2) chk("slow_starved_pixel", 32'(pix2), 32'h0);
    end
    if (hh == 1008) begin
      nl = (vv == 665) ? 0 : vv + 1;
      if (nl < 600) begin
        m_next   = base_of(nl);
        m_left   = rec ? -1 : 0;
        exp_addr = 18'(base_of(nl));
      end
    end
    repeat (3) tick();
  endtask

  task automatic tail(input int vv);
    for (int hh = 1008; hh < 1040; hh++) px(hh, vv);
  endtask

  task automatic play(input int vv, input int n);
    for (int hh = 0; hh < n; hh++) px(hh, vv);
    tail(vv);
  endtask

  // Every SRAM read start must address the next byte of the current line.
  initial begin : mon
    logic pcs;
    pcs = 1'b1;
    forever begin
      @(negedge clk);
      if (pcs && !cs1 && rst_n) begin
        reads++;
        if (mon_en) begin
          chk("read_addr", 32'(addr1), 32'(exp_addr));
          exp_addr = exp_addr + 18'd1;
        end
      end
      pcs = cs1;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int         rd0;
    logic [17:0] a_hold;
    rst_n = 1'b0; pix_ce = 1'b0; h = '0; v = '0; de = 1'b0; rec = 1'b1;
    repeat (3) tick();
    chk("rst_addr", 32'(addr1), 32'h0);
    chk("rst_cs", 32'(cs1), 32'h1);
    chk("rst_oe", 32'(oe1), 32'h1);
    chk("rst_we", 32'(we1), 32'h1);
    chk("rst_pixel", 32'(pix1), 32'h0);
    chk("rst_underrun", 32'(und1), 32'h0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_before_reload", 32'(reads), 32'h0);
    mon_en = 1'b1;

    // Frame 1: line 0 in full, then line pairs sharing a base.
    tail(665);
    play(0, 800);
    chk("line0_underrun", 32'(und1), 32'h0);
    chk("slow_underrun", 32'(und2), 32'h1);
    play(1, 40);
    play(2, 40);
    play(3, 40);
    play(4, 40);
    for (int vv = 5; vv < 9; vv++) px(1008, vv);
    tail(9);

    // Record mode from mid-line 10: FIFO drains its 4 bytes then starves.
    for (int hh = 0; hh <= 200; hh++) px(hh, 10);
    rec = 1'b0;
    m_left = 4;
    tick();
    chk("rec_cs", 32'(cs1), 32'h1);
    chk("rec_oe", 32'(oe1), 32'h1);
    a_hold = addr1;
    rd0 = reads;
    for (int hh = 201; hh < 800; hh++) px(hh, 10);
    chk("rec_underrun", 32'(und1), 32'h1);
    chk("rec_addr_held", 32'(addr1), 32'(a_hold));
    chk("rec_no_reads", 32'(reads), 32'(rd0));
    tail(10);
    for (int hh = 0; hh < 40; hh++) px(hh, 11);
    rec = 1'b1;
    rd0 = reads;
    for (int hh = 40; hh < 100; hh++) px(hh, 11);
    chk("no_midline_resume", 32'(reads), 32'(rd0));
    tail(11);
    play(12, 80);

    // Skip to the last active line.
    for (int vv = 13; vv < 598; vv++) px(1008, vv);
    tail(598);
    play(599, 60);
    chk("underrun_before_wrap", 32'(und1), 32'h1);

    // Frame 2 wraps to address 0 and clears underrun.
    tail(665);
    chk("underrun_cleared", 32'(und1), 32'h0);
    play(0, 60);

    // Asynchronous reset in the middle of a read.
    px(1008, 1);
    for (int i = 0; i < 10 && cs1 !== 1'b0; i++) tick();
    chk("read_in_flight", 32'(cs1), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs", 32'(cs1), 32'h1);
    chk("async_rst_oe", 32'(oe1), 32'h1);
    chk("async_rst_addr", 32'(addr1), 32'h0);
    chk("async_rst_pixel", 32'(pix1), 32'h0);
    chk("async_rst_underrun", 32'(und2), 32'h0);
    tick();
    rst_n = 1'b1;
    rd0 = reads;
    repeat (30) tick();
    chk("no_fetch_after_reset", 32'(reads), 32'(rd0));
    tail(665);
    play(0, 40);
    chk("final_underrun", 32'(und1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
